// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite row streamer slice.
package sprite_pkg;

    // Default sprite geometry used by the streamer, its interface and the ROM.
    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_SPR_W       = 16;
    localparam int DEF_SPR_H       = 12;
    localparam int DEF_COLOR_W     = 3;

    // Streamer control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_e;

    // Bits needed to index 'value' items; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/sprite_row_streamer_if.sv
// Request and pixel-stream bundle between the object scheduler, the streamer and the line-buffer writer.
interface sprite_row_streamer_if
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int SPR_W       = DEF_SPR_W,
    parameter int SPR_H       = DEF_SPR_H,
    parameter int COLOR_W     = DEF_COLOR_W
) ();

    localparam int ID_W  = clog2(NUM_SPRITES);
    localparam int ROW_W = clog2(SPR_H);
    localparam int COL_W = clog2(SPR_W);

    logic               start;
    logic [ID_W-1:0]    sprite_id;
    logic [ROW_W-1:0]   row;
    logic               flip_h;
    logic               flip_v;
    logic               busy;
    logic               err;
    logic               pix_valid;
    logic               pix_ready;
    logic [COLOR_W-1:0] pix_color;
    logic               pix_opaque;
    logic [COL_W-1:0]   pix_col;
    logic               pix_last;
    logic               done;

    // Requester / consumer side.
    modport master (
        output start, sprite_id, row, flip_h, flip_v, pix_ready,
        input  busy, err, pix_valid, pix_color, pix_opaque, pix_col, pix_last, done
    );

    // Streamer side.
    modport slave (
        input  start, sprite_id, row, flip_h, flip_v, pix_ready,
        output busy, err, pix_valid, pix_color, pix_opaque, pix_col, pix_last, done
    );

endinterface

// File: rtl/sprite_rom.sv
// Synchronous sprite ROM, one read per enabled clock, output held while the enable is low.
// The image is produced by a built-in deterministic pattern so the block needs no memory file;
// an empty INIT_FILE name yields a blank (all-zero) image.
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int    DEPTH     = DEF_NUM_SPRITES * DEF_SPR_W * DEF_SPR_H,
    parameter int    WIDTH     = DEF_COLOR_W,
    parameter string INIT_FILE = "sprite.mif",
    parameter int    ADDR_W    = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              clken,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  q
);

    localparam bit HAS_IMAGE = (INIT_FILE != "");

    logic [ADDR_W-1:0] mix;
    logic [WIDTH-1:0]  data_d;
    logic [WIDTH-1:0]  data_q;

    // Image pattern: low address bits folded with the bits four places up.
    always_comb begin
        mix    = address ^ (address >> 4);
        data_d = HAS_IMAGE ? WIDTH'(mix) : '0;
    end

    // Read register; keeps its word whenever the consumer stalls.
    always_ff @(posedge clock) begin
        if (clken) begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/sprite_row_streamer.sv
// Streams one sprite row, one pixel per clock, with optional mirroring and a transparency flag.
module sprite_row_streamer
    import sprite_pkg::*;
#(
    parameter int    NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int    SPR_W       = DEF_SPR_W,
    parameter int    SPR_H       = DEF_SPR_H,
    parameter int    COLOR_W     = DEF_COLOR_W,
    parameter int    TRANSP_CODE = 0,
    parameter string INIT_FILE   = "sprite.mif"
) (
    input logic                   clock,
    input logic                   reset,
    sprite_row_streamer_if.slave  bus
);

    localparam int ID_W   = clog2(NUM_SPRITES);
    localparam int ROW_W  = clog2(SPR_H);
    localparam int COL_W  = clog2(SPR_W);
    localparam int DEPTH  = NUM_SPRITES * SPR_W * SPR_H;
    localparam int ADDR_W = clog2(DEPTH);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SPR_H - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               flip_h_q, flip_h_d;
    logic               flip_v_q, flip_v_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               id_ok;
    logic               row_ok;
    logic               handshake;
    logic               rom_ce;
    logic [COL_W-1:0]   col_e;
    logic [ROW_W-1:0]   row_e;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_q;

    // A port that can only carry legal values needs no range comparison.
    if (NUM_SPRITES == (1 << ID_W)) begin : g_id_full
        assign id_ok = 1'b1;
    end else begin : g_id_check
        assign id_ok = (32'(bus.sprite_id) < NUM_SPRITES);
    end

    if (SPR_H == (1 << ROW_W)) begin : g_row_full
        assign row_ok = 1'b1;
    end else begin : g_row_check
        assign row_ok = (32'(bus.row) < SPR_H);
    end

    assign handshake = (state_q == STREAM) && bus.pix_ready;

    // State and request registers; reset discards any row in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            id_q     <= '0;
            row_q    <= '0;
            flip_h_q <= 1'b0;
            flip_v_q <= 1'b0;
            col_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            row_q    <= row_d;
            flip_h_q <= flip_h_d;
            flip_v_q <= flip_v_d;
            col_q    <= col_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next state: accept legal requests while idle, step the column on every accepted pixel.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        row_d    = row_q;
        flip_h_d = flip_h_q;
        flip_v_d = flip_v_q;
        col_d    = col_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (id_ok && row_ok) begin
                        id_d     = bus.sprite_id;
                        row_d    = bus.row;
                        flip_h_d = bus.flip_h;
                        flip_v_d = bus.flip_v;
                        col_d    = '0;
                        state_d  = PRIME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRIME: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (handshake) begin
                    if (col_q == LAST_COL) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ROM read of the column about to be shown; address math kept at 32 bits until the end.
    always_comb begin
        col_e    = flip_h_q ? (LAST_COL - col_d) : col_d;
        row_e    = flip_v_q ? (LAST_ROW - row_q) : row_q;
        rom_addr = ADDR_W'(32'(id_q) * 32'(SPR_W * SPR_H) + 32'(row_e) * 32'(SPR_W) + 32'(col_e));
        rom_ce   = (state_q == PRIME) || handshake;
    end

    // Outputs decoded from the registered state and the ROM word.
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.pix_valid  = (state_q == STREAM);
        bus.pix_last   = (state_q == STREAM) && (col_q == LAST_COL);
        bus.pix_col    = col_q;
        bus.pix_color  = rom_q;
        bus.pix_opaque = (rom_q != COLOR_W'(TRANSP_CODE));
        bus.done       = done_q;
        bus.err        = err_q;
    end

    sprite_rom #(
        .DEPTH     (DEPTH),
        .WIDTH     (COLOR_W),
        .INIT_FILE (INIT_FILE),
        .ADDR_W    (ADDR_W)
    ) u_rom (
        .clock   (clock),
        .clken   (rom_ce),
        .address (rom_addr),
        .q       (rom_q)
    );

endmodule

// File: tb/tb_sprite_row_streamer.sv
// Scoreboard bench for sprite_row_streamer: expected pixels queued at request time, a monitor checks each handshake.
module tb_sprite_row_streamer;
    import sprite_pkg::*;

    typedef struct packed {
        logic [2:0] color;
        logic       opaque;
        logic [3:0] col;
        logic       last;
    } pix_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pix_t expQ[$];
    int   passCount  = 0;
    int   totalCount = 0;
    int   hsCount    = 0;
    int   doneCount  = 0;
    int   readyMode  = 0;

    sprite_row_streamer_if bus ();

    sprite_row_streamer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Expected ROM word: low three address bits XOR address bits 6..4.
    function automatic logic [2:0] romVal(input int a);
        return 3'((a % 8) ^ ((a / 16) % 8));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Queue the 16 pixels a request should produce, in screen order.
    task automatic pushRow(input int id, input int row, input bit fh, input bit fv);
        pix_t p;
        int   colE;
        int   rowE;
        int   a;
        for (int c = 0; c < 16; c++) begin
            colE     = fh ? (15 - c) : c;
            rowE     = fv ? (11 - row) : row;
            a        = id * 192 + rowE * 16 + colE;
            p.color  = romVal(a);
            p.opaque = (p.color != 3'd0);
            p.col    = 4'(c);
            p.last   = (c == 15);
            expQ.push_back(p);
        end
    endtask

    task automatic applyStimulus(input int id, input int row, input bit fh, input bit fv);
        @(posedge clock);
        #1;
        bus.sprite_id = 2'(id);
        bus.row       = 4'(row);
        bus.flip_h    = fh;
        bus.flip_v    = fv;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
            checkOutput({name, "_valid_at_done"}, 32'(bus.pix_valid), 32'd0);
        end
        checkOutput({name, "_sb_empty"}, 32'(expQ.size()), 32'd0);
    endtask

    // Consumer ready pattern: 0 = always ready, 1 = alternate, 2 = five-cycle stall mid-row.
    initial begin
        int cnt;
        int lastMode;
        cnt           = 0;
        lastMode      = 0;
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (readyMode != lastMode) begin
                cnt      = 0;
                lastMode = readyMode;
            end
            cnt++;
            case (readyMode)
                1:       bus.pix_ready = cnt[0];
                2:       bus.pix_ready = !(cnt >= 6 && cnt <= 10);
                default: bus.pix_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compare every handshake against the queue and check stalled outputs stay put.
    initial begin
        pix_t cur;
        pix_t held;
        bit   stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clock);
            cur = {bus.pix_color, bus.pix_opaque, bus.pix_col, bus.pix_last};
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (bus.done) doneCount++;
                if (stalled) begin
                    checkOutput("stall_valid", 32'(bus.pix_valid), 32'd1);
                    checkOutput("stall_hold", 32'(cur), 32'(held));
                end
                if (bus.pix_valid && bus.pix_ready) begin
                    hsCount++;
                    if (expQ.size() == 0) begin
                        checkOutput("sb_underflow", 32'(expQ.size()), 32'd1);
                    end else begin
                        checkOutput("pixel", 32'(cur), 32'(expQ.pop_front()));
                    end
                end
                stalled = bus.pix_valid && !bus.pix_ready;
                held    = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hsBase;
        int doneBase;
        bus.start     = 1'b0;
        bus.sprite_id = '0;
        bus.row       = '0;
        bus.flip_h    = 1'b0;
        bus.flip_v    = 1'b0;
        reset         = 1'b1;
        repeat (3) @(negedge clock);

        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_valid", 32'(bus.pix_valid), 32'd0);
        checkOutput("rst_last", 32'(bus.pix_last), 32'd0);
        checkOutput("rst_col", 32'(bus.pix_col), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;

        $display("[TB] plain row id=1 row=3");
        pushRow(1, 3, 1'b0, 1'b0);
        applyStimulus(1, 3, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("lat_prime_valid", 32'(bus.pix_valid), 32'd0);
        checkOutput("lat_prime_busy", 32'(bus.busy), 32'd1);
        @(negedge clock);
        checkOutput("lat_first_valid", 32'(bus.pix_valid), 32'd1);
        waitDone("plain");

        $display("[TB] flipped row id=1 row=3");
        pushRow(1, 3, 1'b1, 1'b1);
        applyStimulus(1, 3, 1'b1, 1'b1);
        waitDone("flip");

        $display("[TB] alternating ready id=2 row=5");
        readyMode = 1;
        hsBase    = hsCount;
        pushRow(2, 5, 1'b0, 1'b0);
        applyStimulus(2, 5, 1'b0, 1'b0);
        waitDone("toggle");
        checkOutput("toggle_handshakes", 32'(hsCount - hsBase), 32'd16);

        $display("[TB] long stall id=0 row=11 flip_h");
        readyMode = 2;
        hsBase    = hsCount;
        pushRow(0, 11, 1'b1, 1'b0);
        applyStimulus(0, 11, 1'b1, 1'b0);
        waitDone("stall");
        checkOutput("stall_handshakes", 32'(hsCount - hsBase), 32'd16);
        readyMode = 0;

        $display("[TB] out-of-range rows");
        applyStimulus(1, 12, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("err12_pulse", 32'(bus.err), 32'd1);
        checkOutput("err12_busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        checkOutput("err12_clear", 32'(bus.err), 32'd0);
        checkOutput("err12_valid", 32'(bus.pix_valid), 32'd0);
        applyStimulus(3, 15, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("err15_pulse", 32'(bus.err), 32'd1);
        checkOutput("err15_busy", 32'(bus.busy), 32'd0);

        $display("[TB] start while busy, then start in done cycle");
        hsBase = hsCount;
        pushRow(0, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        applyStimulus(2, 7, 1'b1, 1'b0);
        waitDone("ignore");
        checkOutput("ignore_handshakes", 32'(hsCount - hsBase), 32'd16);
        pushRow(3, 11, 1'b0, 1'b1);
        bus.sprite_id = 2'd3;
        bus.row       = 4'd11;
        bus.flip_h    = 1'b0;
        bus.flip_v    = 1'b1;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        @(negedge clock);
        checkOutput("b2b_prime_valid", 32'(bus.pix_valid), 32'd0);
        checkOutput("b2b_prime_busy", 32'(bus.busy), 32'd1);
        @(negedge clock);
        checkOutput("b2b_first_valid", 32'(bus.pix_valid), 32'd1);
        waitDone("b2b");

        $display("[TB] reset mid-row");
        hsBase   = hsCount;
        doneBase = doneCount;
        pushRow(2, 9, 1'b0, 1'b0);
        applyStimulus(2, 9, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (hsCount - hsBase >= 7) break;
        end
        checkOutput("mid_reached_px7", 32'(hsCount - hsBase >= 7), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_rst_valid", 32'(bus.pix_valid), 32'd0);
        checkOutput("mid_rst_last", 32'(bus.pix_last), 32'd0);
        checkOutput("mid_rst_col", 32'(bus.pix_col), 32'd0);
        checkOutput("mid_rst_done", 32'(bus.done), 32'd0);
        expQ.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("mid_no_done", 32'(doneCount - doneBase), 32'd0);
        checkOutput("mid_idle_valid", 32'(bus.pix_valid), 32'd0);
        pushRow(3, 11, 1'b1, 1'b0);
        applyStimulus(3, 11, 1'b1, 1'b0);
        waitDone("after_reset");

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
